iq_link_seq: RTL and testbench
==============================

IQ_LINK_SEQ -- requirements
Module: iq_link_seq

Interface
REQ-001 Parameter FP_PERIOD, default 4, expected clk cycles between consecutive i_fp pulses (31.25 MSPS IQ in 125 MHz domain).
REQ-002 Parameter SETTLE, default 8, clk cycles waited after each enable assertion.
REQ-003 Parameter LOCK_CNT, default 16, consecutive good intervals required to declare alignment.
REQ-004 Parameter LOSS_CNT, default 3, consecutive bad intervals that declare loss of lock.
REQ-005 Parameter TIMEOUT, default 1024, max clk cycles spent in ALIGN before FAULT.
REQ-006 clk  input  1  125 MHz fabric clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 i_enable  input  1  level; 1 = bring link up, 0 = return to IDLE.
REQ-009 i_soft_restart  input  1  single-cycle pulse; forces IDLE from any state.
REQ-010 i_fp  input  1  IQ frame pulse from LVCMOS receive converter, 125 MHz domain.
REQ-011 o_rx_en  output  1  enable for LVCMOS receive converter.
REQ-012 o_tx_en  output  1  enable for LVDS transmit converter.
REQ-013 o_fp_gate  output  1  qualifies i_fp into the LVDS transmitter; 0 blocks samples.
REQ-014 o_locked  output  1  high only in RUN.
REQ-015 o_fault  output  1  high only in FAULT.
REQ-016 o_state  output  3  current state encoding.
REQ-017 o_err_cnt  output  8  saturating count of bad intervals seen in RUN.

Function
REQ-018 States/encoding: IDLE=0, RX_START=1, ALIGN=2, TX_START=3, RUN=4, RECOVER=5, FAULT=6; 7 unused, SHALL go to IDLE.
REQ-019 Interval: cycles from one i_fp-high cycle to the next; pulses at t and t+4 give interval 4; good iff interval == FP_PERIOD.
REQ-020 Missing pulse: interval counter reaching FP_PERIOD+1 without i_fp SHALL register one bad interval and restart counting as if a pulse occurred.
REQ-021 Interval counter restarts on entry to ALIGN; the first i_fp after entry only starts measurement.
REQ-022 IDLE: all enables/gate 0; i_enable=1 -> RX_START next cycle.
REQ-023 RX_START: o_rx_en=1; after SETTLE cycles -> ALIGN.
REQ-024 ALIGN: o_rx_en=1; LOCK_CNT consecutive good intervals -> TX_START; a bad interval zeroes the good count; TIMEOUT cycles in state -> FAULT (lock wins if both same cycle).
REQ-025 TX_START: o_rx_en=o_tx_en=1; after SETTLE cycles, -> RUN on the next i_fp cycle.
REQ-026 RUN: o_fp_gate=1 starting the same cycle as the aligning i_fp (combinational from state only, registered state); LOSS_CNT consecutive bad intervals -> RECOVER; good interval zeroes bad count.
REQ-027 o_err_cnt increments by 1 per bad interval in RUN, saturates at 255, clears only in IDLE.
REQ-028 RECOVER: o_fp_gate=0, o_tx_en=0, o_rx_en=1, one cycle, -> ALIGN.
REQ-029 FAULT: all enables 0, o_fault=1; held until i_enable=0 or i_soft_restart.
REQ-030 Priority each cycle: i_soft_restart > i_enable=0 > state transition; both force IDLE next cycle.
REQ-031 All outputs registered or decoded from registered state; no i_fp combinational path to outputs except none.

Reset
REQ-032 rst_n low: state IDLE, all counters 0, all outputs 0, o_state=0; release synchronous to first clk edge after deassertion.
REQ-033 No output changes in the cycle of reset deassertion.

Structure
REQ-034 Shared package/include holds state encodings and parameter defaults for reuse by the top-level bridge.
REQ-035 One sub-module fp_interval_mon: interval counter, good/bad pulse outputs, restart input.

Verification
REQ-036 i_enable=1, i_fp every 4 cycles -> RX_START 8 cycles, ALIGN, RUN after 16 good intervals + 8 settle + next fp; o_locked=1, o_err_cnt=0.
REQ-037 In RUN, drop 2 fp pulses then resume -> o_err_cnt=2, stays RUN; drop 3 -> RECOVER for 1 cycle, o_fp_gate=0, relock to RUN.
REQ-038 i_fp every 5 cycles -> ALIGN for 1024 cycles -> FAULT, o_fault=1; i_soft_restart pulse -> IDLE next cycle.
REQ-039 i_enable deasserted mid-RUN -> IDLE next cycle, all outputs 0, o_err_cnt cleared.
REQ-040 rst_n asserted in RUN -> outputs 0 immediately (asynchronous); continuous bad intervals for 300 cycles in RUN with LOSS_CNT=1000 -> o_err_cnt saturates at 255.

Source files
------------

// File: rtl/iq_link_seq_pkg.sv
// Shared state encodings, parameter defaults and sizing helper for the IQ link sequencer.
package iq_link_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_START = 3'd1,
    ST_ALIGN    = 3'd2,
    ST_TX_START = 3'd3,
    ST_RUN      = 3'd4,
    ST_RECOVER  = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  localparam int unsigned STATE_W       = 3;
  localparam int unsigned ERR_W         = 8;
  localparam int unsigned DEF_FP_PERIOD = 4;
  localparam int unsigned DEF_SETTLE    = 8;
  localparam int unsigned DEF_LOCK_CNT  = 16;
  localparam int unsigned DEF_LOSS_CNT  = 3;
  localparam int unsigned DEF_TIMEOUT   = 1024;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 32'd2) ? 32'd1 : 32'($clog2(max_val + 32'd1));
  endfunction

endpackage

// File: rtl/fp_interval_mon.sv
// Frame-pulse interval monitor: flags good/bad intervals and predicts the next expected pulse.
module fp_interval_mon
  import iq_link_seq_pkg::*;
#(
  parameter int unsigned FP_PERIOD = DEF_FP_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic fp,
  output logic good_c,
  output logic bad_c,
  output logic due_c
);

  localparam int unsigned CNT_W = cnt_w(FP_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             armed;
  logic             at_period;
  logic             miss;

  // cnt = cycles since the last (real or virtual) pulse; a missing pulse is
  // counted at its expected slot so the pulse grid stays in phase.
  always_comb begin
    at_period = (cnt == CNT_W'(FP_PERIOD));
    miss      = armed && !fp && at_period;
    good_c    = armed && fp && at_period;
    bad_c     = (armed && fp && !at_period) || miss;
    if (fp || miss) begin
      cnt_nxt = CNT_W'(1);
    end else if (armed) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else begin
      cnt_nxt = cnt;
    end
    due_c = !restart && (armed || fp) && (cnt_nxt == CNT_W'(FP_PERIOD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      armed <= armed | fp;
    end
  end

endmodule

// File: rtl/iq_link_seq.sv
// IQ link bring-up sequencer: enables RX/TX converters, aligns to the frame pulse and supervises lock.
module iq_link_seq
  import iq_link_seq_pkg::*;
#(
  parameter int unsigned FP_PERIOD = DEF_FP_PERIOD,
  parameter int unsigned SETTLE    = DEF_SETTLE,
  parameter int unsigned LOCK_CNT  = DEF_LOCK_CNT,
  parameter int unsigned LOSS_CNT  = DEF_LOSS_CNT,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  input  logic               i_soft_restart,
  input  logic               i_fp,
  output logic               o_rx_en,
  output logic               o_tx_en,
  output logic               o_fp_gate,
  output logic               o_locked,
  output logic               o_fault,
  output logic [STATE_W-1:0] o_state,
  output logic [ERR_W-1:0]   o_err_cnt
);

  localparam int unsigned TMR_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int unsigned TMR_W   = cnt_w(TMR_MAX);
  localparam int unsigned GOOD_W  = cnt_w(LOCK_CNT);
  localparam int unsigned LOSS_W  = cnt_w(LOSS_CNT);

  state_t            state;
  state_t            state_nxt;
  logic [TMR_W-1:0]  tmr;
  logic [TMR_W-1:0]  tmr_nxt;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_cnt_nxt;
  logic [LOSS_W-1:0] loss_cnt;
  logic [LOSS_W-1:0] loss_cnt_nxt;
  logic [ERR_W-1:0]  err_cnt_nxt;
  logic              settle_done;
  logic              restart_c;
  logic              good_c;
  logic              bad_c;
  logic              due_c;
  logic              rx_en_nxt;
  logic              tx_en_nxt;

  fp_interval_mon #(
    .FP_PERIOD (FP_PERIOD)
  ) u_mon (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_c),
    .fp      (i_fp),
    .good_c  (good_c),
    .bad_c   (bad_c),
    .due_c   (due_c)
  );

  // Next state, counters and output decode; RUN is entered on the cycle the
  // expected pulse arrives so the gate opens together with that pulse.
  always_comb begin
    state_nxt   = state;
    settle_done = (32'(tmr) + 32'd1) >= SETTLE;
    case (state)
      ST_IDLE:     if (i_enable) state_nxt = ST_RX_START;
      ST_RX_START: if (settle_done) state_nxt = ST_ALIGN;
      ST_ALIGN: begin
        if (good_c && ((32'(good_cnt) + 32'd1) >= LOCK_CNT)) begin
          state_nxt = ST_TX_START;
        end else if ((32'(tmr) + 32'd1) >= TIMEOUT) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_TX_START: if (settle_done && due_c) state_nxt = ST_RUN;
      ST_RUN: begin
        if (bad_c && ((32'(loss_cnt) + 32'd1) >= LOSS_CNT)) state_nxt = ST_RECOVER;
      end
      ST_RECOVER:  state_nxt = ST_ALIGN;
      ST_FAULT:    state_nxt = ST_FAULT;
      default:     state_nxt = ST_IDLE;
    endcase
    if (i_soft_restart || !i_enable) state_nxt = ST_IDLE;

    restart_c = (state_nxt == ST_ALIGN) && (state != ST_ALIGN);

    if (state_nxt != state) begin
      tmr_nxt = '0;
    end else if (tmr != {TMR_W{1'b1}}) begin
      tmr_nxt = tmr + TMR_W'(1);
    end else begin
      tmr_nxt = tmr;
    end

    good_cnt_nxt = good_cnt;
    if (restart_c || (state != ST_ALIGN)) begin
      good_cnt_nxt = '0;
    end else if (good_c) begin
      good_cnt_nxt = good_cnt + GOOD_W'(1);
    end else if (bad_c) begin
      good_cnt_nxt = '0;
    end

    loss_cnt_nxt = loss_cnt;
    if ((state != ST_RUN) || good_c) begin
      loss_cnt_nxt = '0;
    end else if (bad_c) begin
      loss_cnt_nxt = loss_cnt + LOSS_W'(1);
    end

    err_cnt_nxt = o_err_cnt;
    if (state_nxt == ST_IDLE) begin
      err_cnt_nxt = '0;
    end else if ((state == ST_RUN) && bad_c && (o_err_cnt != {ERR_W{1'b1}})) begin
      err_cnt_nxt = o_err_cnt + ERR_W'(1);
    end

    rx_en_nxt = (state_nxt == ST_RX_START) || (state_nxt == ST_ALIGN) ||
                (state_nxt == ST_TX_START) || (state_nxt == ST_RUN) ||
                (state_nxt == ST_RECOVER);
    tx_en_nxt = (state_nxt == ST_TX_START) || (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      good_cnt  <= '0;
      loss_cnt  <= '0;
      o_err_cnt <= '0;
      o_rx_en   <= 1'b0;
      o_tx_en   <= 1'b0;
      o_fp_gate <= 1'b0;
      o_locked  <= 1'b0;
      o_fault   <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      good_cnt  <= good_cnt_nxt;
      loss_cnt  <= loss_cnt_nxt;
      o_err_cnt <= err_cnt_nxt;
      o_rx_en   <= rx_en_nxt;
      o_tx_en   <= tx_en_nxt;
      o_fp_gate <= (state_nxt == ST_RUN);
      o_locked  <= (state_nxt == ST_RUN);
      o_fault   <= (state_nxt == ST_FAULT);
    end
  end

  assign o_state = STATE_W'(state);

endmodule

// File: tb/tb_iq_link_seq.sv
// Self-checking bench for iq_link_seq: directed vector table plus multi-cycle link scenarios.
module tb_iq_link_seq;

  localparam logic [2:0] S_IDLE = 3'd0, S_RX = 3'd1, S_ALIGN = 3'd2, S_TX = 3'd3,
                         S_RUN = 3'd4, S_REC = 3'd5, S_FAULT = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_n_b = 1'b0;
  logic       en = 1'b0;
  logic       sr = 1'b0;
  logic       fp = 1'b0;
  logic       rx, tx, gate, locked, fault;
  logic [2:0] st;
  logic [7:0] err;
  logic       rx_b, tx_b, gate_b, locked_b, fault_b;
  logic [2:0] st_b;
  logic [7:0] err_b;

  int n_tests = 0;
  int n_fail  = 0;
  int fp_period = 0;
  int fp_phase  = 0;
  int fp_skip   = 0;

  typedef struct {
    logic       en;
    logic       sr;
    logic       fp;
    logic [2:0] st;
    logic       rx;
    logic       tx;
    logic       gate;
    logic       locked;
    logic       fault;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[15];

  iq_link_seq u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (en),
    .i_soft_restart (sr),
    .i_fp           (fp),
    .o_rx_en        (rx),
    .o_tx_en        (tx),
    .o_fp_gate      (gate),
    .o_locked       (locked),
    .o_fault        (fault),
    .o_state        (st),
    .o_err_cnt      (err)
  );

  iq_link_seq #(.LOSS_CNT(1000)) u_dut_sat (
    .clk            (clk),
    .rst_n          (rst_n_b),
    .i_enable       (en),
    .i_soft_restart (sr),
    .i_fp           (fp),
    .o_rx_en        (rx_b),
    .o_tx_en        (tx_b),
    .o_fp_gate      (gate_b),
    .o_locked       (locked_b),
    .o_fault        (fault_b),
    .o_state        (st_b),
    .o_err_cnt      (err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic s, input logic f,
                              input logic [2:0] x_st, input logic x_rx);
    vec_t v;
    v.en = e; v.sr = s; v.fp = f;
    v.st = x_st; v.rx = x_rx; v.tx = 1'b0; v.gate = 1'b0;
    v.locked = 1'b0; v.fault = 1'b0; v.err = 8'd0;
    return v;
  endfunction

  // One clock with the frame-pulse generator; samples land 1 ns after the edge.
  task automatic step();
    if (fp_period != 0 && fp_phase == 0) begin
      if (fp_skip > 0) begin
        fp = 1'b0;
        fp_skip--;
      end else begin
        fp = 1'b1;
      end
    end else begin
      fp = 1'b0;
    end
    if (fp_period != 0) fp_phase = (fp_phase + 1) % fp_period;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string name, input logic [2:0] target,
                            input int budget, output int n);
    n = 0;
    while (st != target && n < budget) begin
      step();
      n++;
    end
    chk(name, int'(st), int'(target));
  endtask

  task automatic chk_outs(input string name, input logic x_rx, input logic x_tx,
                          input logic x_gate, input logic x_lock, input logic x_fault);
    chk({name, ".rx_en"},  int'(rx),     int'(x_rx));
    chk({name, ".tx_en"},  int'(tx),     int'(x_tx));
    chk({name, ".fp_gate"}, int'(gate),  int'(x_gate));
    chk({name, ".locked"}, int'(locked), int'(x_lock));
    chk({name, ".fault"},  int'(fault),  int'(x_fault));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = mk(1'b0, 1'b0, 1'b0, S_IDLE, 1'b0);
    vecs[1] = mk(1'b1, 1'b0, 1'b1, S_RX, 1'b1);
    for (int i = 2; i <= 8; i++) vecs[i] = mk(1'b1, 1'b0, 1'(i % 2), S_RX, 1'b1);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, S_ALIGN, 1'b1);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, S_IDLE, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, S_RX, 1'b1);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, S_IDLE, 1'b0);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, S_IDLE, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, S_IDLE, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.state", int'(st), 0);
    chk("reset.err", int'(err), 0);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Vector table: enable/settle/soft-restart/priority
    foreach (vecs[i]) begin
      en = vecs[i].en; sr = vecs[i].sr; fp = vecs[i].fp;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.state", i), int'(st), int'(vecs[i].st));
      chk($sformatf("vec%0d.err", i), int'(err), int'(vecs[i].err));
      chk_outs($sformatf("vec%0d", i), vecs[i].rx, vecs[i].tx, vecs[i].gate,
               vecs[i].locked, vecs[i].fault);
    end
    sr = 1'b0;

    // Bring-up with a pulse every 4 cycles
    fp_period = 4; fp_phase = 0; en = 1'b1;
    wait_state("up.rx", S_RX, 4, n);
    chk("up.rx_latency", n, 1);
    wait_state("up.align", S_ALIGN, 20, n);
    chk("up.rx_settle_len", n, 8);
    wait_state("up.tx", S_TX, 2000, n);
    chk("up.align_len_65_68", int'(n >= 65 && n <= 68), 1);
    chk_outs("up.tx", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_state("up.run", S_RUN, 40, n);
    chk("up.tx_len", n, 11);
    chk("up.run_on_fp", fp_phase, 0);
    chk_outs("up.run", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("up.err", int'(err), 0);
    repeat (20) step();
    chk("up.hold_run", int'(st), int'(S_RUN));

    // Two dropped pulses: counted, link stays up
    fp_skip = 2;
    repeat (16) step();
    chk("drop2.state", int'(st), int'(S_RUN));
    chk("drop2.err", int'(err), 2);

    // Three dropped pulses: one-cycle RECOVER then relock
    fp_skip = 3;
    wait_state("drop3.recover", S_REC, 20, n);
    chk("drop3.err", int'(err), 5);
    chk_outs("drop3.recover", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("drop3.recover_one_cycle", int'(st), int'(S_ALIGN));
    wait_state("drop3.relock", S_RUN, 200, n);
    chk("drop3.relock_locked", int'(locked), 1);
    chk("drop3.err_kept", int'(err), 5);

    // Asynchronous reset in RUN
    #1 rst_n = 1'b0;
    #1;
    chk("areset.state", int'(st), 0);
    chk("areset.err", int'(err), 0);
    chk_outs("areset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("areset.idle", int'(st), int'(S_IDLE));

    // Bring up again, collect one error, then drop enable
    fp_phase = 0; en = 1'b1;
    wait_state("up2.run", S_RUN, 300, n);
    fp_skip = 1;
    repeat (8) step();
    chk("up2.err", int'(err), 1);
    en = 1'b0;
    step();
    chk("disable.state", int'(st), int'(S_IDLE));
    chk("disable.err", int'(err), 0);
    chk_outs("disable", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrong pulse period: ALIGN times out into FAULT
    fp_period = 5; fp_phase = 0; en = 1'b1;
    wait_state("to.align", S_ALIGN, 20, n);
    wait_state("to.fault", S_FAULT, 1100, n);
    chk("to.align_len", n, 1024);
    chk_outs("to.fault", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) step();
    chk("to.fault_held", int'(st), int'(S_FAULT));
    sr = 1'b1;
    step();
    sr = 1'b0;
    chk("to.soft_restart", int'(st), int'(S_IDLE));
    chk("to.fault_clear", int'(fault), 0);
    en = 1'b0;
    step();

    // Error counter saturation on the LOSS_CNT=1000 instance
    rst_n_b = 1'b1;
    fp_period = 4; fp_phase = 0; en = 1'b1;
    n = 0;
    while (st_b != S_RUN && n < 300) begin
      step();
      n++;
    end
    chk("sat.run", int'(st_b), int'(S_RUN));
    chk("sat.err_start", int'(err_b), 0);
    fp_period = 1; fp_phase = 0;
    repeat (100) step();
    chk("sat.err_mid", int'(err_b), 99);
    repeat (200) step();
    chk("sat.err_sat", int'(err_b), 255);
    chk("sat.state", int'(st_b), int'(S_RUN));
    chk("sat.locked", int'(locked_b), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
